key_sequencer: RTL and testbench

KEY_SEQUENCER -- requirements
Module: key_sequencer

---
 rtl/key_sequencer.sv | 161 ++++++++++++++++
 tb/tb_key_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/key_sequencer.sv
// Keypad-driven operand/opcode entry sequencer: debounces KP, collects A, B and opcode,
// starts the ALU, then waits for completion or a timeout before showing the outcome.
module key_sequencer #(
   parameter int DEBOUNCE = 4,
   parameter int TIMEOUT  = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] KB,
   input  logic       KP,
   input  logic       alu_done,
   output logic [3:0] op_a,
   output logic [3:0] op_b,
   output logic [3:0] opcode,
   output logic       alu_start,
   output logic       busy,
   output logic       result_valid,
   output logic       err,
   output logic [2:0] state
);

   localparam logic [2:0] S_GET_A  = 3'd0;
   localparam logic [2:0] S_GET_B  = 3'd1;
   localparam logic [2:0] S_GET_OP = 3'd2;
   localparam logic [2:0] S_RUN    = 3'd3;
   localparam logic [2:0] S_SHOW   = 3'd4;

   localparam logic [7:0]  DB_LAST  = 8'(DEBOUNCE - 1);
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   logic       sync1_q, sync2_q;
   logic [7:0] db_cnt_q, db_cnt_d;
   logic       pressed_q, pressed_d;
   logic       key_evt, key_clr;

   logic [15:0] tmo_cnt_q, tmo_cnt_d;
   logic        run_wait, tmo_hit;

   logic [2:0] state_q, state_d;
   logic [3:0] op_a_q, op_a_d, op_b_q, op_b_d, opcode_q, opcode_d;
   logic       alu_start_q, alu_start_d;
   logic       result_valid_q, result_valid_d;
   logic       err_q, err_d;

   // The counter tracks how long the synchronized level has disagreed with the
   // accepted level; only a full DEBOUNCE-long run flips it, and only rising flips emit an event.
   always_comb begin
      db_cnt_d  = '0;
      pressed_d = pressed_q;
      key_evt   = 1'b0;
      if (sync2_q != pressed_q) begin
         if (db_cnt_q == DB_LAST) begin
            pressed_d = sync2_q;
            key_evt   = sync2_q;
         end else begin
            db_cnt_d = db_cnt_q + 8'd1;
         end
      end
   end

   assign key_clr = (KB == 4'hF);

   // The start cycle itself is excluded from both completion and timeout counting.
   assign run_wait  = (state_q == S_RUN) && !alu_start_q;
   assign tmo_hit   = run_wait && (tmo_cnt_q == TMO_LAST);
   assign tmo_cnt_d = run_wait ? tmo_cnt_q + 16'd1 : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q        <= 1'b0;
         sync2_q        <= 1'b0;
         db_cnt_q       <= '0;
         pressed_q      <= 1'b0;
         tmo_cnt_q      <= '0;
         state_q        <= S_GET_A;
         op_a_q         <= '0;
         op_b_q         <= '0;
         opcode_q       <= '0;
         alu_start_q    <= 1'b0;
         result_valid_q <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         sync1_q        <= KP;
         sync2_q        <= sync1_q;
         db_cnt_q       <= db_cnt_d;
         pressed_q      <= pressed_d;
         tmo_cnt_q      <= tmo_cnt_d;
         state_q        <= state_d;
         op_a_q         <= op_a_d;
         op_b_q         <= op_b_d;
         opcode_q       <= opcode_d;
         alu_start_q    <= alu_start_d;
         result_valid_q <= result_valid_d;
         err_q          <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_GET_A:  if (key_evt && !key_clr) state_d = S_GET_B;
         S_GET_B:  if (key_evt) state_d = key_clr ? S_GET_A : S_GET_OP;
         S_GET_OP: if (key_evt) state_d = key_clr ? S_GET_A : S_RUN;
         S_RUN:    if ((run_wait && alu_done) || tmo_hit) state_d = S_SHOW;
         S_SHOW:   if (key_evt) state_d = S_GET_A;
         default:  state_d = S_GET_A;
      endcase
   end

   always_comb begin
      op_a_d         = op_a_q;
      op_b_d         = op_b_q;
      opcode_d       = opcode_q;
      alu_start_d    = 1'b0;
      result_valid_d = result_valid_q;
      err_d          = err_q;
      case (state_q)
         S_GET_A, S_GET_B, S_GET_OP: begin
            if (key_evt && key_clr) begin
               op_a_d   = '0;
               op_b_d   = '0;
               opcode_d = '0;
            end else if (key_evt) begin
               if (state_q == S_GET_A) op_a_d = KB;
               else if (state_q == S_GET_B) op_b_d = KB;
               else begin
                  opcode_d    = KB;
                  alu_start_d = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (run_wait && alu_done) result_valid_d = 1'b1;
            else if (tmo_hit) err_d = 1'b1;
         end
         S_SHOW: begin
            if (key_evt) begin
               op_a_d         = '0;
               op_b_d         = '0;
               opcode_d       = '0;
               result_valid_d = 1'b0;
               err_d          = 1'b0;
            end
         end
         default: begin
            result_valid_d = 1'b0;
            err_d          = 1'b0;
         end
      endcase
   end

   assign op_a         = op_a_q;
   assign op_b         = op_b_q;
   assign opcode       = opcode_q;
   assign alu_start    = alu_start_q;
   assign busy         = (state_q == S_RUN);
   assign result_valid = result_valid_q;
   assign err          = err_q;
   assign state        = state_q;

endmodule

// File: tb/tb_key_sequencer.sv
// Directed bench for key_sequencer: key entry, clear, completion, timeout,
// glitch rejection and reset behaviour, all sampled on the falling clock edge.
module tb_key_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] KB;
   logic       KP;
   logic       alu_done;
   logic [3:0] op_a, op_b, opcode;
   logic       alu_start, busy, result_valid, err;
   logic [2:0] state;

   int n_tests = 0;
   int n_fail  = 0;
   int n_start = 0;
   int snap;
   bit ok;

   key_sequencer #(.DEBOUNCE(4), .TIMEOUT(16)) dut (
      .clk(clk), .reset(reset), .KB(KB), .KP(KP), .alu_done(alu_done),
      .op_a(op_a), .op_b(op_b), .opcode(opcode), .alu_start(alu_start),
      .busy(busy), .result_valid(result_valid), .err(err), .state(state)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (alu_start) n_start++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic press(input logic [3:0] k, input int hold);
      KB = k;
      KP = 1'b1;
      repeat (hold) @(negedge clk);
      KP = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic wait_start(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (alu_start) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_state"}, 32'(state), 32'd0);
      chk({tag, "_op_a"}, 32'(op_a), 32'd0);
      chk({tag, "_op_b"}, 32'(op_b), 32'd0);
      chk({tag, "_opcode"}, 32'(opcode), 32'd0);
      chk({tag, "_flags"}, 32'({alu_start, busy, result_valid, err}), 32'd0);
   endtask

   initial begin
      reset = 1'b1; KB = 4'h0; KP = 1'b0; alu_done = 1'b0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      reset = 1'b0;
      @(negedge clk);

      // Normal flow with a done pulse in the start cycle that must be ignored
      press(4'h3, 10);
      chk("a_state", 32'(state), 32'd1);
      chk("a_op_a", 32'(op_a), 32'd3);
      press(4'h5, 10);
      chk("b_state", 32'(state), 32'd2);
      chk("b_op_b", 32'(op_b), 32'd5);
      snap = n_start;
      KB = 4'h2; KP = 1'b1;
      wait_start(ok);
      chk("run_start_seen", 32'(ok), 32'd1);
      chk("run_busy", 32'(busy), 32'd1);
      chk("run_opcode", 32'(opcode), 32'd2);
      alu_done = 1'b1;
      @(negedge clk);
      alu_done = 1'b0;
      chk("done_in_start_ignored", 32'(state), 32'd3);
      KB = 4'hF;
      repeat (3) @(negedge clk);
      chk("run_keys_ignored", 32'({op_a, op_b, opcode}), 32'h352);
      alu_done = 1'b1;
      @(negedge clk);
      alu_done = 1'b0;
      chk("show_state", 32'(state), 32'd4);
      chk("show_valid", 32'(result_valid), 32'd1);
      chk("show_err", 32'(err), 32'd0);
      chk("show_busy", 32'(busy), 32'd0);
      chk("show_ops", 32'({op_a, op_b, opcode}), 32'h352);
      chk("one_start", 32'(n_start - snap), 32'd1);
      KP = 1'b0;
      repeat (8) @(negedge clk);

      // A key in SHOW clears everything and is discarded
      press(4'h9, 10);
      chk_all_zero("show_key");

      // Clear from GET_B
      snap = n_start;
      press(4'h4, 10);
      chk("clr_pre_state", 32'(state), 32'd1);
      press(4'hF, 10);
      chk_all_zero("clr_b");
      chk("clr_no_start", 32'(n_start - snap), 32'd0);

      // Timeout: SHOW with err exactly 17 cycles after the start cycle
      press(4'h1, 10);
      press(4'h2, 10);
      KB = 4'h3; KP = 1'b1;
      wait_start(ok);
      chk("tmo_start_seen", 32'(ok), 32'd1);
      repeat (16) @(negedge clk);
      chk("tmo_still_run", 32'(state), 32'd3);
      chk("tmo_no_err_yet", 32'(err), 32'd0);
      @(negedge clk);
      chk("tmo_state", 32'(state), 32'd4);
      chk("tmo_err", 32'(err), 32'd1);
      chk("tmo_valid", 32'(result_valid), 32'd0);
      KP = 1'b0;
      repeat (8) @(negedge clk);
      press(4'h0, 10);
      chk_all_zero("tmo_clear");

      // Short glitches never produce an event
      for (int n = 1; n <= 3; n++) begin
         KB = 4'h6; KP = 1'b1;
         repeat (n) @(negedge clk);
         KP = 1'b0;
         repeat (8) @(negedge clk);
         chk($sformatf("glitch%0d_state", n), 32'(state), 32'd0);
      end
      KB = 4'h7;
      KP = 1'b1; @(negedge clk);
      KP = 1'b0; @(negedge clk);
      KP = 1'b1; @(negedge clk);
      KP = 1'b0; @(negedge clk);
      press(4'h7, 10);
      chk("bounce_state", 32'(state), 32'd1);
      chk("bounce_op_a", 32'(op_a), 32'd7);
      press(4'hF, 10);
      chk_all_zero("bounce_clr");

      // Reset while busy aborts the run without a later start pulse
      press(4'h1, 10);
      press(4'h2, 10);
      KB = 4'h3; KP = 1'b1;
      wait_start(ok);
      chk("rst_start_seen", 32'(ok), 32'd1);
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd1);
      KP = 1'b0;
      #1 reset = 1'b1;
      #1 chk_all_zero("rst_async");
      repeat (2) @(negedge clk);
      reset = 1'b0;
      snap = n_start;
      repeat (20) @(negedge clk);
      chk_all_zero("rst_after");
      chk("rst_no_start", 32'(n_start - snap), 32'd0);
      press(4'h6, 10);
      chk("rst_next_op_a", 32'(op_a), 32'd6);
      chk("rst_next_state", 32'(state), 32'd1);

      // KP held across reset release: event only after sync + debounce
      reset = 1'b1;
      KB = 4'h8; KP = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      chk("held_not_yet", 32'(state), 32'd0);
      @(negedge clk);
      chk("held_state", 32'(state), 32'd1);
      chk("held_op_a", 32'(op_a), 32'd8);
      KP = 1'b0;
      repeat (8) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
